msrv32_machine_counters: RTL and testbench
==========================================

Name: msrv32_machine_counters

Overview:
Machine-mode performance counter unit for the RV32I core. It sits in the stage directly downstream of the decode/execute pipeline register. It consumes the registered CSR address, CSR op, CSR write enable, rs1 and immediate from that register. It owns the 64-bit mcycle and minstret counters and mcountinhibit, returns read data to the write-back mux, and flags illegal writes to read-only counter shadows.

Parameters:
INHIBIT_RESET, 32'h00000000, reset value of mcountinhibit; only bits 0 (CY) and 2 (IR) are implemented.
CYCLE_RESET, 64'h0000000000000000, reset value of mcycle.
INSTRET_RESET, 64'h0000000000000000, reset value of minstret.

Ports:
clk_in  input  1  core clock, rising edge.
reset_in  input  1  asynchronous, active-high reset.
csr_addr_in  input  12  registered CSR address.
csr_op_in  input  3  [1:0]: 00 none, 01 RW, 10 RS, 11 RC; [2]=1 uses zero-extended imm_in[4:0] as source, else rs1_in.
csr_wr_en_in  input  1  registered CSR write enable.
rs1_in  input  32  registered rs1 value.
imm_in  input  32  registered immediate; only [4:0] used.
instret_inc_in  input  1  one instruction retired this cycle.
real_time_in  input  64  platform mtime value, for the time/timeh shadows.
csr_data_out  output  32  read data for the addressed counter CSR.
csr_hit_out  output  1  address maps to this unit.
illegal_csr_out  output  1  effective write to a read-only shadow.

Behaviour:
- Address map:
  - 0xB00 mcycle[31:0], 0xB80 mcycle[63:32].
  - 0xB02 minstret[31:0], 0xB82 minstret[63:32].
  - 0x320 mcountinhibit.
  - Read-only shadows: 0xC00/0xC80 cycle/cycleh = mcycle, 0xC01/0xC81 time/timeh = real_time_in, 0xC02/0xC82 instret/instreth = minstret.
  - Any other address: csr_hit_out=0, csr_data_out=0, illegal_csr_out=0, no state change.
- Read path: combinational from current register state. The value read is the pre-write, pre-increment value of this cycle. Zero-latency read.
- Source: src = csr_op_in[2] ? {27'b0, imm_in[4:0]} : rs1_in.
- Effective write: csr_wr_en_in=1, csr_op_in[1:0]!=00, and (op==RW or src!=0). RS/RC with src==0 is a pure read and never writes.
- New value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
  - mcountinhibit keeps only bits 0 and 2; all other bits read 0.
- Effective write to a read-only shadow: illegal_csr_out=1 combinationally that cycle; no state change.
- Counter update at each rising edge, with priority high to low:
  - Effective write to that half: the half loads the new value.
  - Otherwise mcycle increments by 1 if mcountinhibit[0]=0.
  - Otherwise minstret increments by 1 if instret_inc_in=1 and mcountinhibit[2]=0.
- Split-write rules:
  - Write to the low half: no increment that cycle, and the high half holds.
  - Write to the high half: the low half increments normally, but the carry out of the low half is discarded that cycle.
- 64-bit arithmetic: carry from [31:0] into [63:32]. All-ones wraps to 0 with no flag.
- A written value is visible on the next read. Increments resume on the following edge.
- Writes to mcountinhibit take effect from the next edge; the edge that writes inhibit still increments per the old value.
- Reset (asynchronous, any time, including mid-write): mcycle=CYCLE_RESET, minstret=INSTRET_RESET, mcountinhibit=INHIBIT_RESET (masked). Outputs follow combinationally from the reset state. No increment on the edge where reset is asserted.

Test Plan:
- Reset then 5 idle cycles, instret_inc_in=0 -> read 0xB00 gives 5, 0xC02 gives 0, 0xC00 equals 0xB00, illegal_csr_out=0.
- RW 0xB00 src=0xFFFFFFFE, RW 0xB80 src=0 -> two cycles later 0xB00=0x00000000 and 0xB80=0x00000001.
- RW 0xB00 and 0xB80 to all-ones -> next edge wraps to 64'h0.
- instret_inc_in=1 for 3 cycles; then RS 0x320 with imm=5 -> minstret=3, mcycle frozen. RC 0x320 imm=5 -> both resume counting.
- RW 0xC00 src=0x1234 -> illegal_csr_out=1, mcycle unchanged. RS 0xC00 with src=0 -> illegal_csr_out=0, data=cycle.
- Assert reset_in mid-cycle between edges while a write to 0xB02 is pending -> minstret=0 immediately; write discarded; 0x320 reads 0.

Source files
------------

// File: rtl/msrv32_machine_counters.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : msrv32_machine_counters
// Purpose  : Machine-mode performance counters for the RV32I core. Owns the
//            64-bit mcycle and minstret counters and mcountinhibit. Serves
//            reads of these registers and of the user-level read-only
//            shadows (cycle/time/instret and their high halves). Flags
//            effective writes to the read-only shadows as illegal.
// Ports    : clk_in          - core clock, rising edge
//            reset_in        - asynchronous active-high reset
//            csr_addr_in     - registered CSR address (12 bits)
//            csr_op_in       - [1:0] 00 none/01 RW/10 RS/11 RC,
//                              [2] selects zero-extended imm_in[4:0] as source
//            csr_wr_en_in    - registered CSR write enable
//            rs1_in          - registered rs1 value
//            imm_in          - registered immediate, only [4:0] used
//            instret_inc_in  - one instruction retired this cycle
//            real_time_in    - platform mtime, for the time/timeh shadows
//            csr_data_out    - read data for the addressed counter CSR
//            csr_hit_out     - address maps to this unit
//            illegal_csr_out - effective write to a read-only shadow
// Revision : 1.0 - initial release
// ============================================================================
module msrv32_machine_counters #(
    parameter logic [31:0] INHIBIT_RESET = 32'h0000_0000,
    parameter logic [63:0] CYCLE_RESET   = 64'h0000_0000_0000_0000,
    parameter logic [63:0] INSTRET_RESET = 64'h0000_0000_0000_0000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic        csr_wr_en_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] imm_in,
    input  logic        instret_inc_in,
    input  logic [63:0] real_time_in,
    output logic [31:0] csr_data_out,
    output logic        csr_hit_out,
    output logic        illegal_csr_out
);

    // CSR addresses
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_TIME          = 12'hC01;
    localparam logic [11:0] ADDR_TIMEH         = 12'hC81;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;

    // CSR operation encodings (csr_op_in[1:0])
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    // State
    logic [63:0] mcycle_q;
    logic [63:0] mcycle_d;
    logic [63:0] minstret_q;
    logic [63:0] minstret_d;
    logic        inh_cy_q;
    logic        inh_cy_d;
    logic        inh_ir_q;
    logic        inh_ir_d;

    // Combinational
    logic [31:0] w_src;
    logic        w_wr_req;
    logic [31:0] w_rd_data;
    logic        w_hit;
    logic        w_ro;
    logic [31:0] w_new_val;
    logic        w_cy_en;
    logic        w_ir_en;
    logic        w_wr_mcycle_lo;
    logic        w_wr_mcycle_hi;
    logic        w_wr_minstret_lo;
    logic        w_wr_minstret_hi;
    logic        w_wr_inhibit;
    logic        w_unused_imm;

    // Only the low five immediate bits form the zimm source.
    assign w_unused_imm = &{1'b0, imm_in[31:5]};

    assign w_src = csr_op_in[2] ? {27'b0, imm_in[4:0]} : rs1_in;

    // RS/RC with a zero source are pure reads and must not write, so they
    // cannot trip the read-only check either.
    assign w_wr_req = csr_wr_en_in
                   && (csr_op_in[1:0] != OP_NONE)
                   && ((csr_op_in[1:0] == OP_RW) || (w_src != 32'd0));

    // Address decode and read mux; reads always see the pre-update state.
    always_comb begin
        w_hit     = 1'b0;
        w_ro      = 1'b0;
        w_rd_data = 32'd0;
        case (csr_addr_in)
            ADDR_MCYCLE: begin
                w_hit     = 1'b1;
                w_rd_data = mcycle_q[31:0];
            end
            ADDR_MCYCLEH: begin
                w_hit     = 1'b1;
                w_rd_data = mcycle_q[63:32];
            end
            ADDR_MINSTRET: begin
                w_hit     = 1'b1;
                w_rd_data = minstret_q[31:0];
            end
            ADDR_MINSTRETH: begin
                w_hit     = 1'b1;
                w_rd_data = minstret_q[63:32];
            end
            ADDR_MCOUNTINHIBIT: begin
                w_hit     = 1'b1;
                w_rd_data = {29'd0, inh_ir_q, 1'b0, inh_cy_q};
            end
            ADDR_CYCLE: begin
                w_hit     = 1'b1;
                w_ro      = 1'b1;
                w_rd_data = mcycle_q[31:0];
            end
            ADDR_CYCLEH: begin
                w_hit     = 1'b1;
                w_ro      = 1'b1;
                w_rd_data = mcycle_q[63:32];
            end
            ADDR_TIME: begin
                w_hit     = 1'b1;
                w_ro      = 1'b1;
                w_rd_data = real_time_in[31:0];
            end
            ADDR_TIMEH: begin
                w_hit     = 1'b1;
                w_ro      = 1'b1;
                w_rd_data = real_time_in[63:32];
            end
            ADDR_INSTRET: begin
                w_hit     = 1'b1;
                w_ro      = 1'b1;
                w_rd_data = minstret_q[31:0];
            end
            ADDR_INSTRETH: begin
                w_hit     = 1'b1;
                w_ro      = 1'b1;
                w_rd_data = minstret_q[63:32];
            end
            default: begin
                w_hit     = 1'b0;
                w_ro      = 1'b0;
                w_rd_data = 32'd0;
            end
        endcase
    end

    // Read-modify-write value, based on the value being read this cycle.
    always_comb begin
        w_new_val = w_rd_data;
        case (csr_op_in[1:0])
            OP_RW:   w_new_val = w_src;
            OP_RS:   w_new_val = w_rd_data | w_src;
            OP_RC:   w_new_val = w_rd_data & ~w_src;
            default: w_new_val = w_rd_data;
        endcase
    end

    assign w_wr_mcycle_lo   = w_wr_req && (csr_addr_in == ADDR_MCYCLE);
    assign w_wr_mcycle_hi   = w_wr_req && (csr_addr_in == ADDR_MCYCLEH);
    assign w_wr_minstret_lo = w_wr_req && (csr_addr_in == ADDR_MINSTRET);
    assign w_wr_minstret_hi = w_wr_req && (csr_addr_in == ADDR_MINSTRETH);
    assign w_wr_inhibit     = w_wr_req && (csr_addr_in == ADDR_MCOUNTINHIBIT);

    // Enables use the current inhibit bits, so the edge that writes
    // mcountinhibit still counts according to the old setting.
    assign w_cy_en = ~inh_cy_q;
    assign w_ir_en = instret_inc_in & ~inh_ir_q;

    // Next-state for mcycle. Writing the low half suppresses the increment
    // and holds the high half; writing the high half lets the low half
    // count but drops its carry.
    always_comb begin
        mcycle_d = mcycle_q;
        if (w_wr_mcycle_lo) begin
            mcycle_d = {mcycle_q[63:32], w_new_val};
        end else if (w_wr_mcycle_hi) begin
            mcycle_d = {w_new_val, mcycle_q[31:0] + {31'd0, w_cy_en}};
        end else if (w_cy_en) begin
            mcycle_d = mcycle_q + 64'd1;
        end
    end

    // Next-state for minstret, same split-write rules as mcycle.
    always_comb begin
        minstret_d = minstret_q;
        if (w_wr_minstret_lo) begin
            minstret_d = {minstret_q[63:32], w_new_val};
        end else if (w_wr_minstret_hi) begin
            minstret_d = {w_new_val, minstret_q[31:0] + {31'd0, w_ir_en}};
        end else if (w_ir_en) begin
            minstret_d = minstret_q + 64'd1;
        end
    end

    // Next-state for mcountinhibit; only CY (bit 0) and IR (bit 2) exist.
    always_comb begin
        inh_cy_d = inh_cy_q;
        inh_ir_d = inh_ir_q;
        if (w_wr_inhibit) begin
            inh_cy_d = w_new_val[0];
            inh_ir_d = w_new_val[2];
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            mcycle_q   <= CYCLE_RESET;
            minstret_q <= INSTRET_RESET;
            inh_cy_q   <= INHIBIT_RESET[0];
            inh_ir_q   <= INHIBIT_RESET[2];
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            inh_cy_q   <= inh_cy_d;
            inh_ir_q   <= inh_ir_d;
        end
    end

    assign csr_data_out    = w_rd_data;
    assign csr_hit_out     = w_hit;
    assign illegal_csr_out = w_wr_req & w_ro;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_machine_counters.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_msrv32_machine_counters
// Purpose  : Directed self-checking bench for msrv32_machine_counters.
//            Inputs change on the falling edge; outputs are sampled a few ns
//            later, still before the next rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msrv32_machine_counters;

    logic        clk_in;
    logic        reset_in;
    logic [11:0] csr_addr_in;
    logic [2:0]  csr_op_in;
    logic        csr_wr_en_in;
    logic [31:0] rs1_in;
    logic [31:0] imm_in;
    logic        instret_inc_in;
    logic [63:0] real_time_in;
    logic [31:0] csr_data_out;
    logic        csr_hit_out;
    logic        illegal_csr_out;

    int total;
    int bad;

    msrv32_machine_counters dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .csr_addr_in     (csr_addr_in),
        .csr_op_in       (csr_op_in),
        .csr_wr_en_in    (csr_wr_en_in),
        .rs1_in          (rs1_in),
        .imm_in          (imm_in),
        .instret_inc_in  (instret_inc_in),
        .real_time_in    (real_time_in),
        .csr_data_out    (csr_data_out),
        .csr_hit_out     (csr_hit_out),
        .illegal_csr_out (illegal_csr_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus driver only; no checking here.
    task automatic drive(input logic [11:0] addr, input logic [2:0] op,
                         input logic wr, input logic [31:0] rs1,
                         input logic [31:0] imm);
        csr_addr_in  = addr;
        csr_op_in    = op;
        csr_wr_en_in = wr;
        rs1_in       = rs1;
        imm_in       = imm;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset_in = 1'b1;
        drive(12'hB00, 3'b000, 1'b0, 32'd0, 32'd0);
        instret_inc_in = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (csr_data_out !== 32'd0 || csr_hit_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_mcycle: got data=%h hit=%b want data=0 hit=1", csr_data_out, csr_hit_out);
        end
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        total++;
        if (csr_data_out !== 32'd5) begin
            bad++;
            $display("FAIL idle5_mcycle: got %h want 00000005", csr_data_out);
        end
        drive(12'hC02, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL idle5_instret: got %h want 00000000", csr_data_out);
        end
        drive(12'hC00, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd5 || illegal_csr_out !== 1'b0) begin
            bad++;
            $display("FAIL idle5_cycle: got data=%h ill=%b want 00000005 ill=0", csr_data_out, illegal_csr_out);
        end
        drive(12'h123, 3'b001, 1'b1, 32'hDEAD, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd0 || csr_hit_out !== 1'b0 || illegal_csr_out !== 1'b0) begin
            bad++;
            $display("FAIL unmapped: got data=%h hit=%b ill=%b want 0 0 0", csr_data_out, csr_hit_out, illegal_csr_out);
        end
    endtask

    // Low write then high write: high write drops the carry, next idle edge carries.
    task automatic test_split_write();
        @(negedge clk_in);
        drive(12'hB00, 3'b001, 1'b1, 32'hFFFF_FFFE, 32'd0);
        @(negedge clk_in);
        drive(12'hB80, 3'b001, 1'b1, 32'h0000_0000, 32'd0);
        @(negedge clk_in);
        drive(12'hB00, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL split_lo_nocarry: got %h want ffffffff", csr_data_out);
        end
        drive(12'hB80, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL split_hi_nocarry: got %h want 00000000", csr_data_out);
        end
        @(negedge clk_in);
        drive(12'hB00, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL split_lo_after: got %h want 00000000", csr_data_out);
        end
        drive(12'hB80, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd1) begin
            bad++;
            $display("FAIL split_hi_after: got %h want 00000001", csr_data_out);
        end
    endtask

    // High half first (low carry dropped), then low half holds high: all-ones, then wrap.
    task automatic test_wrap();
        @(negedge clk_in);
        drive(12'hB80, 3'b001, 1'b1, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk_in);
        drive(12'hB00, 3'b001, 1'b1, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk_in);
        drive(12'hB80, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_hi_ones: got %h want ffffffff", csr_data_out);
        end
        drive(12'hB00, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_lo_ones: got %h want ffffffff", csr_data_out);
        end
        @(negedge clk_in);
        #1;
        total++;
        if (csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL wrap_lo_zero: got %h want 00000000", csr_data_out);
        end
        drive(12'hB80, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL wrap_hi_zero: got %h want 00000000", csr_data_out);
        end
    endtask

    task automatic test_inhibit();
        do_reset();
        // mcycle=0, minstret=0 here
        instret_inc_in = 1'b1;
        drive(12'hB02, 3'b000, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        instret_inc_in = 1'b0;
        #1;
        total++;
        if (csr_data_out !== 32'd3) begin
            bad++;
            $display("FAIL instret3: got %h want 00000003", csr_data_out);
        end
        // RS mcountinhibit with zimm=5; this edge still counts mcycle (3->4)
        drive(12'h320, 3'b110, 1'b1, 32'hFFFF_FFFF, 32'd5);
        #1;
        total++;
        if (csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL inhibit_pre: got %h want 00000000", csr_data_out);
        end
        @(negedge clk_in);
        drive(12'h320, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd5) begin
            bad++;
            $display("FAIL inhibit_set: got %h want 00000005", csr_data_out);
        end
        instret_inc_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        instret_inc_in = 1'b0;
        drive(12'hB00, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd4) begin
            bad++;
            $display("FAIL frozen_mcycle: got %h want 00000004", csr_data_out);
        end
        drive(12'hB02, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd3) begin
            bad++;
            $display("FAIL frozen_minstret: got %h want 00000003", csr_data_out);
        end
        // RC clears inhibit; that edge still uses the old (inhibited) value
        drive(12'h320, 3'b111, 1'b1, 32'd0, 32'd5);
        @(negedge clk_in);
        instret_inc_in = 1'b1;
        drive(12'hB00, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd4) begin
            bad++;
            $display("FAIL clear_edge_mcycle: got %h want 00000004", csr_data_out);
        end
        @(negedge clk_in);
        instret_inc_in = 1'b0;
        #1;
        total++;
        if (csr_data_out !== 32'd5) begin
            bad++;
            $display("FAIL resume_mcycle: got %h want 00000005", csr_data_out);
        end
        drive(12'hB02, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd4) begin
            bad++;
            $display("FAIL resume_minstret: got %h want 00000004", csr_data_out);
        end
    endtask

    task automatic test_readonly();
        do_reset();
        drive(12'hC00, 3'b001, 1'b1, 32'h0000_1234, 32'd0);
        #1;
        total++;
        if (illegal_csr_out !== 1'b1 || csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL ro_rw_cycle: got ill=%b data=%h want ill=1 data=00000000", illegal_csr_out, csr_data_out);
        end
        @(negedge clk_in);
        drive(12'hC00, 3'b010, 1'b1, 32'd0, 32'd0);
        #1;
        total++;
        if (illegal_csr_out !== 1'b0 || csr_data_out !== 32'd1) begin
            bad++;
            $display("FAIL ro_rs_zero: got ill=%b data=%h want ill=0 data=00000001", illegal_csr_out, csr_data_out);
        end
        drive(12'hC80, 3'b001, 1'b1, 32'd0, 32'd0);
        #1;
        total++;
        if (illegal_csr_out !== 1'b1) begin
            bad++;
            $display("FAIL ro_rw_zero_cycleh: got ill=%b want 1", illegal_csr_out);
        end
        drive(12'hC02, 3'b110, 1'b1, 32'd0, 32'd3);
        #1;
        total++;
        if (illegal_csr_out !== 1'b1) begin
            bad++;
            $display("FAIL ro_rsi_instret: got ill=%b want 1", illegal_csr_out);
        end
        drive(12'hC01, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'h3456_789A || illegal_csr_out !== 1'b0) begin
            bad++;
            $display("FAIL time_lo: got %h ill=%b want 3456789a ill=0", csr_data_out, illegal_csr_out);
        end
        drive(12'hC81, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'h0000_0012) begin
            bad++;
            $display("FAIL time_hi: got %h want 00000012", csr_data_out);
        end
        @(negedge clk_in);
        drive(12'hB00, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd2) begin
            bad++;
            $display("FAIL ro_no_write: got %h want 00000002", csr_data_out);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk_in);
        drive(12'h320, 3'b001, 1'b1, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk_in);
        drive(12'h320, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd5) begin
            bad++;
            $display("FAIL inhibit_mask: got %h want 00000005", csr_data_out);
        end
        drive(12'hB02, 3'b001, 1'b1, 32'h0000_0055, 32'd0);
        @(negedge clk_in);
        drive(12'hB02, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'h55) begin
            bad++;
            $display("FAIL minstret_written: got %h want 00000055", csr_data_out);
        end
        drive(12'hB02, 3'b001, 1'b1, 32'h0000_ABCD, 32'd0);
        #1;
        reset_in = 1'b1;
        #1;
        total++;
        if (csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL rst_minstret: got %h want 00000000", csr_data_out);
        end
        drive(12'h320, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL rst_inhibit: got %h want 00000000", csr_data_out);
        end
        drive(12'hB02, 3'b001, 1'b1, 32'h0000_ABCD, 32'd0);
        @(posedge clk_in);
        #1;
        total++;
        if (csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL rst_write_dropped: got %h want 00000000", csr_data_out);
        end
        @(negedge clk_in);
        drive(12'hB00, 3'b000, 1'b0, 32'd0, 32'd0);
        reset_in = 1'b0;
        #1;
        total++;
        if (csr_data_out !== 32'd0) begin
            bad++;
            $display("FAIL rst_no_increment: got %h want 00000000", csr_data_out);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset_in       = 1'b1;
        instret_inc_in = 1'b0;
        real_time_in   = 64'h0000_0012_3456_789A;
        drive(12'hB00, 3'b000, 1'b0, 32'd0, 32'd0);
        test_reset();
        test_split_write();
        test_wrap();
        test_inhibit();
        test_readonly();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
